// File: rtl/alu_accumulator_if.sv
// Operand/command and result/status bundle between the CPU datapath and the ALU accumulator.
interface alu_accumulator_if #(
    parameter int unsigned WIDTH = 8
) ();
    logic [WIDTH-1:0] Operand;
    logic [2:0]       Op;
    logic             Start;
    logic             Busy;
    logic             Done;
    logic [WIDTH-1:0] Acc;
    logic [WIDTH-1:0] AccHi;
    logic             CarryFlag;
    logic             ZeroFlag;

    modport master (
        output Operand, Op, Start,
        input  Busy, Done, Acc, AccHi, CarryFlag, ZeroFlag
    );

    modport slave (
        input  Operand, Op, Start,
        output Busy, Done, Acc, AccHi, CarryFlag, ZeroFlag
    );
endinterface

// File: rtl/alu_accumulator.sv
// Accumulator ALU: single-cycle load/arith/logic/shift ops and a shift-and-add multiply.
// Results, flags, Busy and Done are all registered.
module alu_accumulator #(
    parameter int unsigned WIDTH = 8
) (
    input  logic                Clk,
    input  logic                Reset_n,
    alu_accumulator_if.slave    bus
);
    localparam int unsigned CW   = $clog2(WIDTH);
    localparam int unsigned PW   = 2 * WIDTH;
    localparam logic [2:0] OP_LOAD = 3'b000;
    localparam logic [2:0] OP_ADD  = 3'b001;
    localparam logic [2:0] OP_SUB  = 3'b010;
    localparam logic [2:0] OP_AND  = 3'b011;
    localparam logic [2:0] OP_OR   = 3'b100;
    localparam logic [2:0] OP_XOR  = 3'b101;
    localparam logic [2:0] OP_SHL  = 3'b110;
    localparam logic [2:0] OP_MUL  = 3'b111;

    typedef enum logic {S_IDLE, S_MUL} state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] acc_q, acc_d;
    logic [WIDTH-1:0] hi_q, hi_d;
    logic             carry_q, carry_d;
    logic             zero_q, zero_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic [PW-1:0]    mcand_q, mcand_d;
    logic [WIDTH-1:0] mplier_q, mplier_d;
    logic [PW-1:0]    prod_q, prod_d;
    logic [CW-1:0]    cnt_q, cnt_d;

    logic [WIDTH:0]   sum;
    logic [WIDTH:0]   diff;
    logic [PW-1:0]    prod_next;

    // Next-state and datapath update
    always_comb begin
        state_d   = state_q;
        acc_d     = acc_q;
        hi_d      = hi_q;
        carry_d   = carry_q;
        zero_d    = zero_q;
        busy_d    = busy_q;
        done_d    = 1'b0;
        mcand_d   = mcand_q;
        mplier_d  = mplier_q;
        prod_d    = prod_q;
        cnt_d     = cnt_q;
        sum       = {1'b0, acc_q} + {1'b0, bus.Operand};
        diff      = {1'b0, acc_q} - {1'b0, bus.Operand};
        prod_next = prod_q + (mplier_q[0] ? mcand_q : PW'(0));

        unique case (state_q)
            S_IDLE: begin
                if (bus.Start) begin
                    if (bus.Op == OP_MUL) begin
                        mcand_d  = PW'(acc_q);
                        mplier_d = bus.Operand;
                        prod_d   = '0;
                        cnt_d    = '0;
                        busy_d   = 1'b1;
                        state_d  = S_MUL;
                    end else begin
                        done_d = 1'b1;
                        case (bus.Op)
                            OP_LOAD: acc_d = bus.Operand;
                            OP_ADD:  {carry_d, acc_d} = sum;
                            OP_SUB: begin
                                acc_d   = diff[WIDTH-1:0];
                                carry_d = diff[WIDTH];
                            end
                            OP_AND:  acc_d = acc_q & bus.Operand;
                            OP_OR:   acc_d = acc_q | bus.Operand;
                            OP_XOR:  acc_d = acc_q ^ bus.Operand;
                            OP_SHL: begin
                                carry_d = acc_q[WIDTH-1];
                                acc_d   = {acc_q[WIDTH-2:0], 1'b0};
                            end
                            default: acc_d = acc_q;
                        endcase
                        zero_d = (acc_d == '0);
                    end
                end
            end
            S_MUL: begin
                prod_d   = prod_next;
                mplier_d = mplier_q >> 1;
                mcand_d  = mcand_q << 1;
                cnt_d    = cnt_q + CW'(1);
                if (cnt_q == CW'(WIDTH - 1)) begin
                    acc_d   = prod_next[WIDTH-1:0];
                    hi_d    = prod_next[PW-1:WIDTH];
                    carry_d = (prod_next[PW-1:WIDTH] != '0);
                    zero_d  = (prod_next[WIDTH-1:0] == '0);
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state_q  <= S_IDLE;
            acc_q    <= '0;
            hi_q     <= '0;
            carry_q  <= 1'b0;
            zero_q   <= 1'b1;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            mcand_q  <= '0;
            mplier_q <= '0;
            prod_q   <= '0;
            cnt_q    <= '0;
        end else begin
            state_q  <= state_d;
            acc_q    <= acc_d;
            hi_q     <= hi_d;
            carry_q  <= carry_d;
            zero_q   <= zero_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
            prod_q   <= prod_d;
            cnt_q    <= cnt_d;
        end
    end

    assign bus.Acc       = acc_q;
    assign bus.AccHi     = hi_q;
    assign bus.CarryFlag = carry_q;
    assign bus.ZeroFlag  = zero_q;
    assign bus.Busy      = busy_q;
    assign bus.Done      = done_q;
endmodule

// File: tb/tb_alu_accumulator.sv
// Self-checking bench for alu_accumulator: reference model feeds a scoreboard queue,
// a Done monitor pops and compares, scenario tasks add targeted checks.
module tb_alu_accumulator;
    logic Clk = 1'b0;
    logic Reset_n;

    always #5 Clk = ~Clk;

    alu_accumulator_if #(.WIDTH(8)) bus ();

    alu_accumulator #(.WIDTH(8)) dut (
        .Clk     (Clk),
        .Reset_n (Reset_n),
        .bus     (bus)
    );

    typedef struct packed {
        logic [7:0] acc;
        logic [7:0] hi;
        logic       c;
        logic       z;
    } exp_t;

    exp_t sb[$];
    exp_t mon_exp;
    exp_t mon_got;
    int   total = 0;
    int   bad = 0;
    int   done_cnt = 0;

    logic [7:0] m_acc, m_hi;
    logic       m_c, m_z;

    task automatic model_reset();
        m_acc = 8'h00;
        m_hi  = 8'h00;
        m_c   = 1'b0;
        m_z   = 1'b1;
        sb.delete();
    endtask

    // Drive one request for one clock edge and queue the model's expectation.
    task automatic issue(input logic [2:0] op, input logic [7:0] opnd);
        logic [8:0]  t;
        logic [15:0] p;
        bus.Op      = op;
        bus.Operand = opnd;
        bus.Start   = 1'b1;
        case (op)
            3'd0: m_acc = opnd;
            3'd1: begin
                t     = 9'(m_acc) + 9'(opnd);
                m_c   = t[8];
                m_acc = t[7:0];
            end
            3'd2: begin
                m_c   = (m_acc < opnd);
                m_acc = m_acc - opnd;
            end
            3'd3: m_acc = m_acc & opnd;
            3'd4: m_acc = m_acc | opnd;
            3'd5: m_acc = m_acc ^ opnd;
            3'd6: begin
                m_c   = m_acc[7];
                m_acc = {m_acc[6:0], 1'b0};
            end
            default: begin
                p     = 16'(m_acc) * 16'(opnd);
                m_acc = p[7:0];
                m_hi  = p[15:8];
                m_c   = (m_hi != 8'h00);
            end
        endcase
        m_z = (m_acc == 8'h00);
        sb.push_back('{acc: m_acc, hi: m_hi, c: m_c, z: m_z});
        @(posedge Clk);
        #1;
        bus.Start = 1'b0;
    endtask

    // Scoreboard monitor: every Done pulse must match the oldest queued expectation.
    always @(negedge Clk) begin
        if (Reset_n === 1'b1 && bus.Done === 1'b1) begin
            done_cnt++;
            total++;
            if (bus.Busy !== 1'b0) begin
                bad++;
                $display("FAIL done_while_busy busy=%b required=0", bus.Busy);
            end
            total++;
            mon_got = {bus.Acc, bus.AccHi, bus.CarryFlag, bus.ZeroFlag};
            if (sb.size() == 0) begin
                bad++;
                $display("FAIL unexpected_done acc=%h hi=%h c=%b z=%b", bus.Acc, bus.AccHi, bus.CarryFlag, bus.ZeroFlag);
            end else begin
                mon_exp = sb.pop_front();
                if (mon_got !== mon_exp) begin
                    bad++;
                    $display("FAIL result acc=%h hi=%h c=%b z=%b required acc=%h hi=%h c=%b z=%b",
                             mon_got.acc, mon_got.hi, mon_got.c, mon_got.z,
                             mon_exp.acc, mon_exp.hi, mon_exp.c, mon_exp.z);
                end
            end
        end
    end

    task automatic test_reset();
        logic [19:0] got;
        bus.Start   = 1'b0;
        bus.Op      = 3'd0;
        bus.Operand = 8'h00;
        Reset_n     = 1'b1;
        #1 Reset_n  = 1'b0;
        model_reset();
        repeat (2) @(posedge Clk);
        @(negedge Clk);
        Reset_n = 1'b1;
        issue(3'd0, 8'hAA);
        @(negedge Clk);
        #2;
        Reset_n = 1'b0;
        model_reset();
        #1;
        got = {bus.Acc, bus.AccHi, bus.CarryFlag, bus.ZeroFlag, bus.Busy, bus.Done};
        total++;
        if (got !== {8'h00, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0}) begin
            bad++;
            $display("FAIL reset_async acc=%h hi=%h c=%b z=%b busy=%b done=%b required 00 00 0 1 0 0",
                     bus.Acc, bus.AccHi, bus.CarryFlag, bus.ZeroFlag, bus.Busy, bus.Done);
        end
        @(negedge Clk);
        Reset_n = 1'b1;
    endtask

    task automatic test_add_wrap();
        int d0;
        d0 = done_cnt;
        issue(3'd0, 8'hFF);
        issue(3'd1, 8'h01);
        @(negedge Clk);
        #1;
        total++;
        if ({bus.Acc, bus.CarryFlag, bus.ZeroFlag} !== {8'h00, 1'b1, 1'b1}) begin
            bad++;
            $display("FAIL add_wrap acc=%h c=%b z=%b required 00 1 1", bus.Acc, bus.CarryFlag, bus.ZeroFlag);
        end
        total++;
        if (done_cnt - d0 != 2) begin
            bad++;
            $display("FAIL add_done_count got=%0d required=2", done_cnt - d0);
        end
        @(negedge Clk);
        #1;
        total++;
        if (bus.Done !== 1'b0) begin
            bad++;
            $display("FAIL done_one_cycle done=%b required=0", bus.Done);
        end
    endtask

    task automatic test_sub_logic();
        issue(3'd0, 8'h05);
        issue(3'd2, 8'h07);
        @(negedge Clk);
        #1;
        total++;
        if ({bus.Acc, bus.CarryFlag, bus.ZeroFlag} !== {8'hFE, 1'b1, 1'b0}) begin
            bad++;
            $display("FAIL sub_borrow acc=%h c=%b z=%b required fe 1 0", bus.Acc, bus.CarryFlag, bus.ZeroFlag);
        end
        issue(3'd3, 8'h0F);
        @(negedge Clk);
        #1;
        total++;
        if ({bus.Acc, bus.CarryFlag} !== {8'h0E, 1'b1}) begin
            bad++;
            $display("FAIL and_keeps_carry acc=%h c=%b required 0e 1", bus.Acc, bus.CarryFlag);
        end
    endtask

    task automatic test_shl();
        issue(3'd0, 8'h81);
        issue(3'd6, 8'hA5);
        @(negedge Clk);
        #1;
        total++;
        if ({bus.Acc, bus.CarryFlag} !== {8'h02, 1'b1}) begin
            bad++;
            $display("FAIL shl_first acc=%h c=%b required 02 1", bus.Acc, bus.CarryFlag);
        end
        issue(3'd6, 8'h00);
        @(negedge Clk);
        #1;
        total++;
        if ({bus.Acc, bus.CarryFlag} !== {8'h04, 1'b0}) begin
            bad++;
            $display("FAIL shl_second acc=%h c=%b required 04 0", bus.Acc, bus.CarryFlag);
        end
    endtask

    task automatic test_mul();
        int busy_cycles;
        issue(3'd0, 8'h19);
        issue(3'd7, 8'h0C);
        bus.Operand = 8'h00;
        busy_cycles = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge Clk);
            #1;
            if (i == 2) begin
                bus.Op      = 3'd0;
                bus.Operand = 8'h55;
                bus.Start   = 1'b1;
            end else begin
                bus.Start = 1'b0;
            end
            if (bus.Busy === 1'b1) busy_cycles++;
            else break;
        end
        bus.Start = 1'b0;
        total++;
        if (busy_cycles != 8) begin
            bad++;
            $display("FAIL mul_busy_cycles got=%0d required=8", busy_cycles);
        end
        total++;
        if (bus.Done !== 1'b1) begin
            bad++;
            $display("FAIL mul_done done=%b required=1", bus.Done);
        end
        total++;
        if ({bus.Acc, bus.AccHi, bus.CarryFlag, bus.ZeroFlag} !== {8'h2C, 8'h01, 1'b1, 1'b0}) begin
            bad++;
            $display("FAIL mul_result acc=%h hi=%h c=%b z=%b required 2c 01 1 0",
                     bus.Acc, bus.AccHi, bus.CarryFlag, bus.ZeroFlag);
        end
        @(negedge Clk);
        #1;
        total++;
        if (sb.size() != 0) begin
            bad++;
            $display("FAIL mul_queue_drained pending=%0d required=0", sb.size());
        end
    endtask

    task automatic test_reset_mid_mul();
        int d0;
        issue(3'd0, 8'h10);
        issue(3'd7, 8'h10);
        repeat (3) @(posedge Clk);
        @(negedge Clk);
        total++;
        if (bus.Busy !== 1'b1) begin
            bad++;
            $display("FAIL mid_mul_busy busy=%b required=1", bus.Busy);
        end
        d0 = done_cnt;
        Reset_n = 1'b0;
        model_reset();
        #1;
        total++;
        if ({bus.Acc, bus.AccHi, bus.CarryFlag, bus.ZeroFlag, bus.Busy, bus.Done} !==
            {8'h00, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0}) begin
            bad++;
            $display("FAIL mid_mul_reset acc=%h hi=%h c=%b z=%b busy=%b done=%b required 00 00 0 1 0 0",
                     bus.Acc, bus.AccHi, bus.CarryFlag, bus.ZeroFlag, bus.Busy, bus.Done);
        end
        repeat (3) @(negedge Clk);
        Reset_n = 1'b1;
        repeat (8) @(negedge Clk);
        #1;
        total++;
        if (done_cnt != d0 || bus.Done !== 1'b0) begin
            bad++;
            $display("FAIL aborted_mul_done dones=%0d required=0", done_cnt - d0);
        end
        issue(3'd0, 8'h03);
        @(negedge Clk);
        #1;
        total++;
        if ({bus.Acc, bus.AccHi, bus.ZeroFlag} !== {8'h03, 8'h00, 1'b0}) begin
            bad++;
            $display("FAIL load_after_reset acc=%h hi=%h z=%b required 03 00 0", bus.Acc, bus.AccHi, bus.ZeroFlag);
        end
    endtask

    task automatic test_back_to_back();
        logic [2:0] op;
        logic [7:0] opnd;
        for (int n = 0; n < 24; n++) begin
            op   = 3'($urandom_range(0, 7));
            opnd = 8'($urandom);
            if (n == 3 || n == 4) op = 3'd7;
            issue(op, opnd);
            if (op == 3'd7) begin
                for (int i = 0; i < 12; i++) begin
                    @(negedge Clk);
                    if (bus.Busy === 1'b0) break;
                end
                total++;
                if (bus.Busy !== 1'b0) begin
                    bad++;
                    $display("FAIL b2b_mul_timeout busy=%b required=0", bus.Busy);
                end
            end
        end
        repeat (2) @(negedge Clk);
        #1;
        total++;
        if (sb.size() != 0) begin
            bad++;
            $display("FAIL b2b_queue_drained pending=%0d required=0", sb.size());
        end
    endtask

    initial begin
        test_reset();
        test_add_wrap();
        test_sub_logic();
        test_shl();
        test_mul();
        test_reset_mid_mul();
        test_back_to_back();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
